// File: rtl/mdio_peripheral.sv
// PHY-side Clause-22 MDIO responder: oversamples MDC in the clk domain and decodes frames.
// Writes strobe into a register file; reads turn the bus around and shift 16 bits out.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  output logic        mdio_in,
  output logic        mdio_oe,
  input  logic [15:0] rd_data,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_stb,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, START, OPCODE, PHYAD, REGAD, TA_WR, DATA_WR, TA_RD, DATA_RD, SKIP
  } state_t;

  state_t      state;
  logic        mdc_q, armed, is_rd, rise;
  logic [4:0]  cnt;
  logic [15:0] sh, sh_nxt;

  // armed masks the first clk after reset so a high MDC is not seen as a rise
  assign rise   = mdc & ~mdc_q & armed;
  assign sh_nxt = {sh[14:0], mdio_out};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mdc_q   <= 1'b0;
      armed   <= 1'b0;
      is_rd   <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      mdio_in <= 1'b0;
      mdio_oe <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
    end else begin
      mdc_q  <= mdc;
      armed  <= 1'b1;
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      if (rise) begin
        cnt <= cnt + 5'd1;
        case (state)
          IDLE: if (!mdio_out) begin state <= START; cnt <= '0; end
          START: begin
            state <= mdio_out ? OPCODE : IDLE;
            cnt   <= '0;
          end
          OPCODE: begin
            sh <= sh_nxt;
            if (cnt == 5'd1) begin
              cnt   <= '0;
              is_rd <= (sh_nxt[1:0] == 2'b10);
              state <= (sh_nxt[1:0] == 2'b01 || sh_nxt[1:0] == 2'b10) ? PHYAD : IDLE;
            end
          end
          PHYAD: begin
            sh <= sh_nxt;
            if (cnt == 5'd4) begin
              cnt   <= '0;
              state <= (sh_nxt[4:0] == PHY_ADDR) ? REGAD : SKIP;
            end
          end
          REGAD: begin
            sh <= sh_nxt;
            if (cnt == 5'd4) begin
              cnt    <= '0;
              addr   <= sh_nxt[4:0];
              rd_stb <= is_rd;
              state  <= is_rd ? TA_RD : TA_WR;
            end
          end
          TA_WR: begin
            if (cnt == 5'd0 && !mdio_out) begin state <= IDLE; cnt <= '0; end
            if (cnt == 5'd1) begin
              cnt   <= '0;
              state <= mdio_out ? IDLE : DATA_WR;
            end
          end
          DATA_WR: begin
            sh <= sh_nxt;
            if (cnt == 5'd15) begin
              cnt     <= '0;
              wr_data <= sh_nxt;
              wr_stb  <= 1'b1;
              state   <= IDLE;
            end
          end
          TA_RD: begin
            if (cnt == 5'd0) begin
              sh      <= rd_data;
              mdio_oe <= 1'b1;
              mdio_in <= 1'b0;
            end else begin
              mdio_in <= sh[15];
              cnt     <= '0;
              state   <= DATA_RD;
            end
          end
          DATA_RD: begin
            if (cnt == 5'd15) begin
              mdio_oe <= 1'b0;
              cnt     <= '0;
              state   <= IDLE;
            end else begin
              sh      <= {sh[14:0], 1'b0};
              mdio_in <= sh[14];
            end
          end
          // foreign PHYAD: REGAD, TA and DATA still to pass (23 rises)
          SKIP: if (cnt == 5'd22) begin state <= IDLE; cnt <= '0; end
          default: begin state <= IDLE; cnt <= '0; end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Directed bench for mdio_peripheral: bit-banged MDC/MDIO frames with hand-computed expectations.
module tb_mdio_peripheral;
  logic        clk = 1'b0, reset = 1'b1, mdc = 1'b0, mdio_out = 1'b1;
  logic [15:0] rd_data = '0;
  logic        mdio_in, mdio_oe, wr_stb, rd_stb, busy;
  logic [4:0]  addr;
  logic [15:0] wr_data;

  int total = 0, bad = 0, hp = 4;
  int wr_cnt = 0, rd_cnt = 0, oe_seen = 0, overlap = 0, dbl = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  logic [15:0] rd_resp = '0;
  logic s_in, s_oe;

  always #5 clk = ~clk;

  mdio_peripheral #(.PHY_ADDR(5'd6)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_out(mdio_out),
    .mdio_in(mdio_in), .mdio_oe(mdio_oe), .rd_data(rd_data),
    .addr(addr), .wr_data(wr_data), .wr_stb(wr_stb), .rd_stb(rd_stb), .busy(busy)
  );

  // strobe monitor plus register-file read responder
  always @(negedge clk) begin
    if (wr_stb) wr_cnt++;
    if (rd_stb) rd_cnt++;
    if (mdio_oe) oe_seen++;
    if (wr_stb && rd_stb) overlap++;
    if ((wr_stb && prev_wr) || (rd_stb && prev_rd)) dbl++;
    prev_wr = wr_stb;
    prev_rd = rd_stb;
    if (rd_stb) rd_data = rd_resp;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // one MDC period: low hp clk with data set up, then high hp clk; outputs sampled at the end
  task automatic mbit(input logic b);
    mdc = 1'b0;
    mdio_out = b;
    repeat (hp) @(negedge clk);
    mdc = 1'b1;
    repeat (hp) @(negedge clk);
    s_in = mdio_in;
    s_oe = mdio_oe;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mbit(v[i]);
  endtask

  task automatic wr_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                          input logic [1:0] ta, input logic [15:0] d);
    send({2'b01, op, phy, ra, ta, d}, 32);
  endtask

  task automatic rd_frame(input string tg, input logic [4:0] ra, input logic [15:0] resp);
    int r0;
    r0 = rd_cnt;
    rd_resp = resp;
    send({18'd0, 2'b01, 2'b10, 5'd6, ra}, 14);
    chk({tg, "_rdstb"}, rd_cnt - r0, 1);
    chk({tg, "_addr"}, addr, ra);
    mbit(1'b1);
    chk({tg, "_ta_oe"}, s_oe, 1);
    chk({tg, "_ta_in"}, s_in, 0);
    for (int i = 15; i >= 0; i--) begin
      mbit(1'b1);
      chk($sformatf("%s_bit%0d", tg, i), s_in, resp[i]);
    end
    mbit(1'b1);
    chk({tg, "_release"}, s_oe, 0);
    chk({tg, "_busy"}, busy, 0);
  endtask

  initial begin
    int w0, o0, r0;
    repeat (3) @(negedge clk);
    chk("rst_oe", mdio_oe, 0);
    chk("rst_in", mdio_in, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_stb", {wr_stb, rd_stb}, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // write at MDC period 8 clk
    w0 = wr_cnt; o0 = oe_seen;
    send(32'hFFFF_FFFF, 8);
    wr_frame(2'b01, 5'd6, 5'd27, 2'b10, 16'h746E);
    chk("w1_addr", addr, 27);
    chk("w1_data", wr_data, 16'h746E);
    chk("w1_stb", wr_cnt - w0, 1);
    chk("w1_oe", oe_seen - o0, 0);
    chk("w1_busy", busy, 0);

    // read of 0xA5C3
    rd_frame("r1", 5'd27, 16'hA5C3);

    // PHYAD mismatch followed immediately by a valid write
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_seen;
    wr_frame(2'b01, 5'd7, 5'd9, 2'b10, 16'h0000);
    chk("mm_stb", (wr_cnt - w0) + (rd_cnt - r0), 0);
    chk("mm_oe", oe_seen - o0, 0);
    chk("mm_addr", addr, 27);
    wr_frame(2'b01, 5'd6, 5'd3, 2'b10, 16'h1234);
    chk("mm_w_addr", addr, 3);
    chk("mm_w_data", wr_data, 16'h1234);
    chk("mm_w_stb", wr_cnt - w0, 1);

    // bad TA, then bad OP, then a valid write
    w0 = wr_cnt;
    wr_frame(2'b01, 5'd6, 5'd9, 2'b11, 16'hFFFF);
    chk("bta_stb", wr_cnt - w0, 0);
    chk("bta_data", wr_data, 16'h1234);
    chk("bta_busy", busy, 0);
    send({2'b01, 2'b11, 28'hFFF_FFFF}, 32);
    chk("bop_stb", wr_cnt - w0, 0);
    chk("bop_busy", busy, 0);
    send(32'hFFFF_FFFF, 32);
    wr_frame(2'b01, 5'd6, 5'd5, 2'b10, 16'hBEEF);
    chk("bad_next_addr", addr, 5);
    chk("bad_next_data", wr_data, 16'hBEEF);
    chk("bad_next_stb", wr_cnt - w0, 1);

    // preamble, read, then reset during DATA_RD while MDC is high
    send(32'hFFFF_FFFF, 32);
    rd_resp = 16'hA5C3;
    send({18'd0, 2'b01, 2'b10, 5'd6, 5'd27}, 14);
    w0 = wr_cnt; r0 = rd_cnt;
    send(32'hF, 5);
    chk("mr_oe_before", s_oe, 1);
    mdio_out = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_oe", mdio_oe, 0);
    chk("mr_in", mdio_in, 0);
    chk("mr_addr", addr, 0);
    chk("mr_wdata", wr_data, 0);
    chk("mr_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("mr_no_rise", busy, 0);
    chk("mr_stb", (wr_cnt - w0) + (rd_cnt - r0), 0);
    wr_frame(2'b01, 5'd6, 5'd17, 2'b10, 16'hC001);
    chk("mr_w_addr", addr, 17);
    chk("mr_w_data", wr_data, 16'hC001);
    chk("mr_w_stb", wr_cnt - w0, 1);

    // minimum MDC, write then read back to back
    hp = 2;
    w0 = wr_cnt;
    wr_frame(2'b01, 5'd6, 5'd12, 2'b10, 16'h0F0F);
    chk("b2b_w_data", wr_data, 16'h0F0F);
    chk("b2b_w_addr", addr, 12);
    chk("b2b_w_stb", wr_cnt - w0, 1);
    rd_frame("b2b_r", 5'd12, 16'h3C5A);
    wr_frame(2'b01, 5'd6, 5'd30, 2'b10, 16'h8001);
    chk("b2b_w2_data", wr_data, 16'h8001);
    chk("b2b_w2_stb", wr_cnt - w0, 2);
    chk("overlap", overlap, 0);
    chk("single_cycle", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
